// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and parity helper for the UART byte receiver.
// Defining UART_RX_PARITY_EN adds one even-parity bit after the data (8E1 instead of 8N1).
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ  = 32'd50_000_000;
    localparam int unsigned DEF_BAUD_RATE = 32'd115_200;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_e;

    // Parity bit that makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Serial input and received-byte outputs of the UART byte receiver.
// The receiver uses the master modport, the consuming stage uses slave.
interface uart_byte_rx_if;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       rx_busy;

    modport master (input uart_rxd, output rx_data, rx_ready, frame_err, rx_busy);
    modport slave  (output uart_rxd, input rx_data, rx_ready, frame_err, rx_busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; both flops reset to 1 (idle line).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic ff1_q;
    logic ff2_q;

    // Two-stage metastability filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= 1'b1;
            ff2_q <= 1'b1;
        end else begin
            ff1_q <= d;
            ff2_q <= ff1_q;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: samples each bit mid-period, pulses rx_ready or frame_err per frame.
// Optional even parity is enabled by defining UART_RX_PARITY_EN.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
    parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_byte_rx_if.master rx_if
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam int          CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    logic             rxd_sync_s;
    logic             fall_s;
    logic             stop_ok_s;
    rx_state_e        state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shreg_q,     shreg_d;
    logic             rxd_prev_q;
    logic [1:0]       arm_q,       arm_d;
    logic [7:0]       rx_data_q,   rx_data_d;
    logic             rx_ready_q,  rx_ready_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_busy_q,   rx_busy_d;
`ifdef UART_RX_PARITY_EN
    logic             par_err_q,   par_err_d;
`endif

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_if.uart_rxd),
        .q     (rxd_sync_s)
    );

    // Edges are ignored until the synchronizer holds real line samples, so a line
    // that is already low when reset is released cannot look like a start bit.
    assign fall_s = (arm_q == 2'd3) && rxd_prev_q && !rxd_sync_s;
`ifdef UART_RX_PARITY_EN
    assign stop_ok_s = rxd_sync_s && !par_err_q;
`else
    assign stop_ok_s = rxd_sync_s;
`endif

    // Next-state logic for the frame FSM, baud counter and output pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_ready_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        if (arm_q == 2'd3) begin
            arm_d = arm_q;
        end else begin
            arm_d = arm_q + 2'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    state_d = ST_START;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                    if (!rxd_sync_s) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d     = CNT_ZERO;
                    shreg_d   = {rxd_sync_s, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d     = CNT_ZERO;
                    par_err_d = (rxd_sync_s != even_parity(shreg_q));
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                // Return to IDLE mid stop bit so a start bit right after a 1-bit stop is caught.
                if (cnt_q == BAUD_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                    if (stop_ok_s) begin
                        rx_data_d  = shreg_q;
                        rx_ready_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        rx_busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'h00;
            rxd_prev_q  <= 1'b1;
            arm_q       <= 2'd0;
            rx_data_q   <= 8'h00;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rxd_prev_q  <= rxd_sync_s;
            arm_q       <= arm_d;
            rx_data_q   <= rx_data_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_ready  = rx_ready_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at 50 MHz / 115200 baud.
// Frames are built bit by bit from the UART framing rules; UART_RX_PARITY_EN selects 8E1.
module tb_uart_byte_rx;
    import uart_pkg::*;

    localparam int unsigned CLK_FREQ  = 50_000_000;
    localparam int unsigned BAUD_RATE = 115200;
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int HALF_DIV = BAUD_DIV / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // start edge -> 2 sync clks + half bit + remaining bits to the stop sample + output register
    localparam int EXP_LAT = 2 + HALF_DIV + (FRAME_BITS - 1) * BAUD_DIV + 1;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_flip;
        int         exp_ready;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    uart_byte_rx_if u_if ();

    int  tests_run = 0;
    int  fails     = 0;
    int  ready_cnt = 0;
    int  err_cnt   = 0;
    int  both_cnt  = 0;
    ev_t obs_q[$];

    uart_byte_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 120000 cycles");
        $fatal(1, "watchdog");
    end

    // Record every output pulse seen on the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (u_if.rx_ready && u_if.frame_err) both_cnt++;
            if (u_if.rx_ready) begin
                ready_cnt++;
                obs_q.push_back('{err: 1'b0, data: u_if.rx_data});
            end
            if (u_if.frame_err) begin
                err_cnt++;
                obs_q.push_back('{err: 1'b1, data: 8'h00});
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_clks(input int n);
        u_if.uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        u_if.uart_rxd = b;
        repeat (BAUD_DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_b);
        u_if.uart_rxd = 1'b1;
    endtask

    initial begin
        vec_t       vecs[$];
        ev_t        exp_q[$];
        logic [7:0] bb[8];
        logic [7:0] d;
        logic [7:0] last_good;
        logic       stop_b;
        logic       flip;
        int         r0, e0, lat;

        vecs.push_back('{data: 8'hA5, stop_bit: 1'b1, par_flip: 1'b0, exp_ready: 1, exp_err: 0, exp_data: 8'hA5});
        vecs.push_back('{data: 8'h11, stop_bit: 1'b1, par_flip: 1'b0, exp_ready: 1, exp_err: 0, exp_data: 8'h11});
        vecs.push_back('{data: 8'h3C, stop_bit: 1'b0, par_flip: 1'b0, exp_ready: 0, exp_err: 1, exp_data: 8'h11});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{data: 8'h07, stop_bit: 1'b1, par_flip: 1'b1, exp_ready: 0, exp_err: 1, exp_data: 8'h11});
        vecs.push_back('{data: 8'h07, stop_bit: 1'b1, par_flip: 1'b0, exp_ready: 1, exp_err: 0, exp_data: 8'h07});
`endif
        bb = '{8'h00, 8'h64, 8'h00, 8'h32, 8'h01, 8'h90, 8'h00, 8'hC8};

        // Reset values
        u_if.uart_rxd = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_data",   u_if.rx_data,   8'h00);
        check("reset_rx_ready",  u_if.rx_ready,  1'b0);
        check("reset_frame_err", u_if.frame_err, 1'b0);
        check("reset_rx_busy",   u_if.rx_busy,   1'b0);
        rst_n = 1'b1;
        idle_clks(20);

        // Latency from start edge to rx_ready on a random byte
        d  = 8'($urandom_range(0, 255));
        r0 = ready_cnt;
        fork
            send_frame(d, 1'b1, 1'b0);
            begin
                lat = 0;
                do begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                end while (!u_if.rx_ready && lat < EXP_LAT + BAUD_DIV);
            end
        join
        tests_run++;
        if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin
            fails++;
            $display("FAIL latency: got %0d clks, expected %0d +/- 1", lat, EXP_LAT);
        end
        idle_clks(4);
        check("latency_data",  u_if.rx_data,  d);
        check("latency_count", ready_cnt - r0, 1);

        // Table-driven single frames
        for (int v = 0; v < vecs.size(); v++) begin
            r0 = ready_cnt;
            e0 = err_cnt;
            send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].par_flip);
            idle_clks(4);
            check($sformatf("vec%0d_ready", v), ready_cnt - r0, vecs[v].exp_ready);
            check($sformatf("vec%0d_err",   v), err_cnt - e0,   vecs[v].exp_err);
            check($sformatf("vec%0d_data",  v), u_if.rx_data,   vecs[v].exp_data);
            check($sformatf("vec%0d_busy",  v), u_if.rx_busy,   1'b0);
        end
        last_good = vecs[vecs.size() - 1].exp_data;

        // False start: short low glitch
        r0 = ready_cnt;
        e0 = err_cnt;
        u_if.uart_rxd = 1'b0;
        repeat (50) @(negedge clk);
        check("false_start_busy_mid", u_if.rx_busy, 1'b1);
        repeat (50) @(negedge clk);
        idle_clks(2 * BAUD_DIV);
        check("false_start_ready", ready_cnt - r0, 0);
        check("false_start_err",   err_cnt - e0,   0);
        check("false_start_busy",  u_if.rx_busy,   1'b0);
        check("false_start_data",  u_if.rx_data,   last_good);

        // Break: line held low well past one frame
        r0 = ready_cnt;
        e0 = err_cnt;
        u_if.uart_rxd = 1'b0;
        repeat ((FRAME_BITS + 1) * BAUD_DIV) @(negedge clk);
        check("break_err_once",  err_cnt - e0, 1);
        check("break_busy_low",  u_if.rx_busy, 1'b0);
        idle_clks(BAUD_DIV);
        check("break_err_total", err_cnt - e0,   1);
        check("break_ready",     ready_cnt - r0, 0);

        // Back-to-back frames with 1-bit stop
        obs_q.delete();
        for (int i = 0; i < 8; i++) send_frame(bb[i], 1'b1, 1'b0);
        idle_clks(4);
        check("b2b_count", obs_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < obs_q.size()) begin
                check($sformatf("b2b%0d_kind", i), obs_q[i].err,  1'b0);
                check($sformatf("b2b%0d_data", i), obs_q[i].data, bb[i]);
            end
        end
        last_good = bb[7];

        // Random frames against the framing model
        obs_q.delete();
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            d      = 8'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            flip   = ($urandom_range(0, 3) == 0);
`else
            flip   = 1'b0;
`endif
            send_frame(d, stop_b, flip);
            if (stop_b && !flip) begin
                exp_q.push_back('{err: 1'b0, data: d});
                last_good = d;
                idle_clks($urandom_range(0, 1) * BAUD_DIV);
            end else begin
                exp_q.push_back('{err: 1'b1, data: 8'h00});
                idle_clks(BAUD_DIV);
            end
        end
        idle_clks(4);
        check("rand_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                check($sformatf("rand%0d_event", i), obs_q[i], exp_q[i]);
            end
        end
        check("rand_last_data", u_if.rx_data, last_good);

        // Reset in the middle of data bit 4
        r0 = ready_cnt;
        e0 = err_cnt;
        d  = 8'hF3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        u_if.uart_rxd = d[4];
        repeat (HALF_DIV) @(negedge clk);
        rst_n = 1'b0;
        u_if.uart_rxd = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_rx_data",   u_if.rx_data,   8'h00);
        check("midrst_rx_ready",  u_if.rx_ready,  1'b0);
        check("midrst_frame_err", u_if.frame_err, 1'b0);
        check("midrst_rx_busy",   u_if.rx_busy,   1'b0);
        rst_n = 1'b1;
        idle_clks(BAUD_DIV);
        check("midrst_no_ready", ready_cnt - r0, 0);
        check("midrst_no_err",   err_cnt - e0,   0);
        check("midrst_busy",     u_if.rx_busy,   1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle_clks(4);
        check("post_rst_data",  u_if.rx_data,   8'h5A);
        check("post_rst_ready", ready_cnt - r0, 1);
        check("post_rst_err",   err_cnt - e0,   0);

        check("ready_err_overlap", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
